// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Imported by the interface, the baud counter and the top.
package uart_pkg;

  localparam int DATA_W            = 8;
  localparam int FRAME_BITS        = 10;
  localparam int CLKS_PER_BIT_DFLT = 868;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle seen by the UART transmitter.
// master = transmitter side, slave = FIFO side.
interface fifo_uart_tx_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_wen;
  logic              fifo_ren;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    input  fifo_wen,
    output fifo_ren
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    output fifo_wen,
    input  fifo_ren
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high,
// pulses bit_tick on the final count and wraps; clear forces 0.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick = run && (cnt_q == LAST);

  // next count: clear wins, otherwise step and wrap on the tick
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = bit_tick ? '0 : cnt_q + CW'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO and sends them as 8N1 UART frames.
// A read blocked by a same-cycle FIFO write is retried from IDLE.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy
);

  state_e            state_q, state_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_q, bit_d;

  logic cnt_clr;
  logic cnt_run;
  logic bit_tick;

  assign cnt_clr = (state_q == IDLE) ||
                   (state_q == REQ)  ||
                   (state_q == LOAD);
  assign cnt_run = !cnt_clr;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clr),
    .run     (cnt_run),
    .bit_tick(bit_tick)
  );

  assign fifo.fifo_ren = (state_q == REQ);
  assign busy          = (state_q != IDLE);
  assign tx            = tx_q;

  // frame sequencing; tx changes on the edge entering each bit
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (enable && !fifo.fifo_empty) state_d = REQ;
      end
      REQ: begin
        state_d = fifo.fifo_wen ? IDLE : LOAD;
      end
      LOAD: begin
        shift_d = fifo.fifo_dout;
        bit_d   = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (bit_tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // FSM registers; reset drops any byte in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, UART receiver model and
// an ideal-waveform model of the expected tx line.
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int FRAME = FRAME_BITS * CPB;
  localparam int GAP   = 3;
  localparam int PITCH = FRAME + GAP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       wen = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] dout_q = 8'h00;
  logic       empty_q = 1'b1;
  logic       tx;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  logic       tx_log[$];
  logic       ren_log[$];
  logic       busy_log[$];
  int         exp_s[$];
  logic [7:0] exp_b[$];
  int         got_s[$];
  logic [7:0] got_b[$];
  logic [7:0] gb0, gb1;

  fifo_uart_tx_if fif();

  assign fif.fifo_dout  = dout_q;
  assign fif.fifo_empty = empty_q;
  assign fif.fifo_wen   = wen;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .fifo  (fif),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // 16-deep FIFO: write beats read, Dout registered after a read
  always @(posedge clk) begin
    if (wen) begin
      if (q.size() < 16) q.push_back(wdata);
    end else if (fif.fifo_ren && q.size() > 0) begin
      dout_q <= q.pop_front();
    end
    empty_q <= (q.size() == 0);
  end

  task automatic fifo_write(input logic [7:0] b);
    @(negedge clk);
    wen   = 1'b1;
    wdata = b;
    @(negedge clk);
    wen   = 1'b0;
  endtask

  // k=0 is the current negedge; optional write and enable drop
  task automatic capture(input int n, input int wen_k,
                         input logic [7:0] wen_d,
                         input int drop_k);
    tx_log.delete();
    ren_log.delete();
    busy_log.delete();
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (k == wen_k) begin
        wen   = 1'b1;
        wdata = wen_d;
      end else if (k == wen_k + 1) begin
        wen = 1'b0;
      end
      if (k == drop_k) enable = 1'b0;
      tx_log.push_back(tx);
      ren_log.push_back(fif.fifo_ren);
      busy_log.push_back(busy);
    end
  endtask

  // ideal line level at sample k given frames exp_s/exp_b
  function automatic logic exp_tx(input int k);
    for (int i = 0; i < exp_s.size(); i++) begin
      if (k >= exp_s[i] && k < exp_s[i] + FRAME) begin
        int idx;
        idx = (k - exp_s[i]) / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return exp_b[i][idx-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic int wave_errs();
    int bad = 0;
    for (int k = 0; k < tx_log.size(); k++)
      if (tx_log[k] !== exp_tx(k)) bad++;
    return bad;
  endfunction

  // UART receiver: find falling edges, sample mid-bit
  function automatic void decode();
    int k = 1;
    got_b.delete();
    got_s.delete();
    while (k + FRAME <= tx_log.size()) begin
      if (tx_log[k-1] === 1'b1 && tx_log[k] === 1'b0) begin
        logic [7:0] b;
        for (int i = 0; i < 8; i++)
          b[i] = tx_log[k + CPB*(i+1) + CPB/2];
        got_b.push_back(b);
        got_s.push_back(k);
        k += FRAME;
      end else begin
        k++;
      end
    end
  endfunction

  function automatic int count_of(input logic v[$]);
    int c = 0;
    foreach (v[i]) if (v[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int bytes_errs();
    int bad = 0;
    if (got_b.size() != exp_b.size()) return 100;
    foreach (exp_b[i]) if (got_b[i] !== exp_b[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    #2 rst = 1'b0;
    enable = 1'b1;
    fifo_write(8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1 || fif.fifo_ren !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold: tx=%b ren=%b busy=%b want 1 0 0",
                 tx, fif.fifo_ren, busy);
      end
    end
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    capture(10, -1, 8'h00, -1);
    n_cmp++;
    if (count_of(ren_log) + count_of(busy_log) != 0) begin
      n_bad++;
      $display("FAIL reset_release_idle: ren+busy=%0d want 0",
               count_of(ren_log) + count_of(busy_log));
    end
  endtask

  task automatic test_single();
    int fall = -1;
    enable = 1'b1;
    capture(60, -1, 8'h00, -1);
    enable = 1'b0;
    exp_s = '{3};
    exp_b = '{8'hA5};
    decode();
    foreach (tx_log[k]) if (fall < 0 && tx_log[k] === 1'b0) fall = k;
    n_cmp++;
    if (wave_errs() != 0) begin
      n_bad++;
      $display("FAIL single_wave: %0d bad samples want 0", wave_errs());
    end
    n_cmp++;
    if (count_of(ren_log) != 1 || ren_log[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ren: pulses=%0d ren@1=%b want 1 1",
               count_of(ren_log), ren_log[1]);
    end
    n_cmp++;
    if (fall != 3) begin
      n_bad++;
      $display("FAIL single_latency: fall at %0d want 3", fall);
    end
    n_cmp++;
    if (count_of(busy_log) != 42) begin
      n_bad++;
      $display("FAIL single_busy: %0d cycles want 42", count_of(busy_log));
    end
    n_cmp++;
    if (bytes_errs() != 0) begin
      n_bad++;
      $display("FAIL single_byte: got %0d bytes first=%h want A5",
               got_b.size(), got_b.size() > 0 ? got_b[0] : 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    int gap_bad = 0;
    exp_b = '{8'h00, 8'hFF, 8'h3C};
    exp_s = '{3, 3 + PITCH, 3 + 2*PITCH};
    foreach (exp_b[i]) fifo_write(exp_b[i]);
    enable = 1'b1;
    capture(3*PITCH + 20, -1, 8'h00, -1);
    enable = 1'b0;
    decode();
    n_cmp++;
    if (wave_errs() != 0) begin
      n_bad++;
      $display("FAIL b2b_wave: %0d bad samples want 0", wave_errs());
    end
    n_cmp++;
    if (bytes_errs() != 0) begin
      n_bad++;
      $display("FAIL b2b_bytes: %0d errors (%0d frames) want 0/3",
               bytes_errs(), got_b.size());
    end
    for (int i = 1; i < got_s.size(); i++)
      if (got_s[i] - got_s[i-1] != PITCH) gap_bad++;
    n_cmp++;
    if (gap_bad != 0 || got_s.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_gap: %0d bad gaps, %0d frames want 0 3",
               gap_bad, got_s.size());
    end
    n_cmp++;
    if (count_of(ren_log) != 3) begin
      n_bad++;
      $display("FAIL b2b_ren: %0d pulses want 3", count_of(ren_log));
    end
    n_cmp++;
    if (empty_q !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: empty=%b busy=%b want 1 0", empty_q, busy);
    end
  endtask

  task automatic test_collision();
    logic [7:0] stale;
    int stale_hits = 0;
    stale = dout_q;
    fifo_write(8'h12);
    enable = 1'b1;
    capture(3 + 2*PITCH + 15, 1, 8'h77, -1);
    enable = 1'b0;
    exp_s = '{5, 5 + PITCH};
    exp_b = '{8'h12, 8'h77};
    decode();
    n_cmp++;
    if (ren_log[1] !== 1'b1 || busy_log[2] !== 1'b0 ||
        ren_log[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL coll_retry: ren1=%b busy2=%b ren3=%b want 1 0 1",
               ren_log[1], busy_log[2], ren_log[3]);
    end
    n_cmp++;
    if (wave_errs() != 0) begin
      n_bad++;
      $display("FAIL coll_wave: %0d bad samples want 0", wave_errs());
    end
    n_cmp++;
    if (bytes_errs() != 0) begin
      n_bad++;
      $display("FAIL coll_order: %0d errors (%0d frames) want 0/2",
               bytes_errs(), got_b.size());
    end
    foreach (got_b[i]) if (got_b[i] === stale) stale_hits++;
    n_cmp++;
    if (stale_hits != 0) begin
      n_bad++;
      $display("FAIL coll_stale: stale %h sent %0d times want 0",
               stale, stale_hits);
    end
    n_cmp++;
    if (count_of(ren_log) != 3) begin
      n_bad++;
      $display("FAIL coll_ren: %0d pulses want 3", count_of(ren_log));
    end
  endtask

  task automatic test_midreset();
    fifo_write(8'hC3);
    enable = 1'b1;
    capture(21, -1, 8'h00, -1);
    n_cmp++;
    if (tx_log[20] !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_bit3: tx=%b want 0", tx_log[20]);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || fif.fifo_ren !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_async: tx=%b ren=%b busy=%b want 1 0 0",
               tx, fif.fifo_ren, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    capture(30, -1, 8'h00, -1);
    enable = 1'b0;
    exp_s.delete();
    exp_b.delete();
    n_cmp++;
    if (wave_errs() != 0 || count_of(ren_log) != 0) begin
      n_bad++;
      $display("FAIL midrst_after: %0d low samples, %0d ren want 0 0",
               wave_errs(), count_of(ren_log));
    end
  endtask

  task automatic test_enable_gating();
    gb0 = 8'($urandom);
    gb1 = 8'($urandom);
    fifo_write(gb0);
    fifo_write(gb1);
    capture(50, -1, 8'h00, -1);
    n_cmp++;
    if (count_of(ren_log) != 0) begin
      n_bad++;
      $display("FAIL gate_off: %0d ren want 0", count_of(ren_log));
    end
    enable = 1'b1;
    capture(100, -1, 8'h00, 4);
    exp_s = '{3};
    exp_b = '{gb0};
    decode();
    n_cmp++;
    if (count_of(ren_log) != 1) begin
      n_bad++;
      $display("FAIL gate_ren: %0d pulses want 1", count_of(ren_log));
    end
    n_cmp++;
    if (wave_errs() != 0 || bytes_errs() != 0) begin
      n_bad++;
      $display("FAIL gate_frame: wave=%0d bytes=%0d want 0 0",
               wave_errs(), bytes_errs());
    end
    n_cmp++;
    if (busy !== 1'b0 || empty_q !== 1'b0) begin
      n_bad++;
      $display("FAIL gate_end: busy=%b empty=%b want 0 0", busy, empty_q);
    end
  endtask

  task automatic test_random();
    int n;
    n = $urandom_range(2, 4);
    exp_b = '{gb1};
    for (int i = 0; i < n; i++) exp_b.push_back(8'($urandom));
    exp_s.delete();
    for (int i = 0; i <= n; i++) exp_s.push_back(3 + i*PITCH);
    for (int i = 1; i <= n; i++) fifo_write(exp_b[i]);
    enable = 1'b1;
    capture((n+1)*PITCH + 10, -1, 8'h00, -1);
    enable = 1'b0;
    decode();
    n_cmp++;
    if (wave_errs() != 0) begin
      n_bad++;
      $display("FAIL rand_wave: %0d bad samples want 0", wave_errs());
    end
    n_cmp++;
    if (bytes_errs() != 0) begin
      n_bad++;
      $display("FAIL rand_bytes: %0d errors, %0d frames want 0 %0d",
               bytes_errs(), got_b.size(), n + 1);
    end
    n_cmp++;
    if (count_of(ren_log) != n + 1 || empty_q !== 1'b1) begin
      n_bad++;
      $display("FAIL rand_ren: %0d pulses empty=%b want %0d 1",
               count_of(ren_log), empty_q, n + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_collision();
    test_midreset();
    test_enable_gating();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
